// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM measurement block.
package pwm_meas_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_DUTY_W      = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Saturation value of a w-bit counter; also the stuck-input timeout.
  function automatic logic [63:0] cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_meas_div.sv
// Sequential restoring divider: quo = floor(num * 2^DUTY_W / den), one bit per cycle.
// Requires num < den so the quotient fits in DUTY_W bits.
module pwm_meas_div
  import pwm_meas_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned DUTY_W = DEF_DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quo
);

  localparam int unsigned    STEP_W = (DUTY_W > 1) ? $clog2(DUTY_W) : 1;
  localparam logic [STEP_W-1:0] LAST = STEP_W'(DUTY_W - 1);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  den_r;
  logic [DUTY_W-1:0] quo_r;
  logic [STEP_W-1:0] step;

  logic [CNT_W:0]    shifted;
  logic [CNT_W-1:0]  diff;
  logic              ge;
  logic [CNT_W-1:0]  rem_nx;
  logic [DUTY_W-1:0] quo_nx;

  // rem < den always, so the shifted remainder needs one extra bit and the
  // difference (taken only when shifted >= den) fits back into CNT_W bits.
  always_comb begin
    shifted = {rem, 1'b0};
    ge      = (shifted >= {1'b0, den_r});
    diff    = shifted[CNT_W-1:0] - den_r;
    rem_nx  = ge ? diff : shifted[CNT_W-1:0];
    quo_nx  = (quo_r << 1) | DUTY_W'(ge);
  end

  assign done = busy && (step == LAST);
  assign quo  = quo_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      step  <= '0;
      rem   <= '0;
      den_r <= '0;
      quo_r <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      step  <= '0;
      rem   <= num;
      den_r <= den;
      quo_r <= '0;
    end else if (busy) begin
      rem   <= rem_nx;
      quo_r <= quo_nx;
      step  <= step + 1'b1;
      if (step == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_meas.sv
// Measures period, high time and duty ratio of an asynchronous PWM input in clk cycles.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DUTY_W      = DEF_DUTY_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o,
  output logic [DUTY_W-1:0] duty_o,
  output logic              meas_valid,
  output logic              stuck,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;
  logic                   rise;
  logic                   fall;

  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       high_r;
  logic [CNT_W-1:0]       pend_period;
  logic [CNT_W-1:0]       pend_high;

  state_t                 state;
  state_t                 state_nx;
  logic                   cap_high;
  logic                   cap_period;
  logic                   timeout;
  logic                   accept;

  logic                   div_busy;
  logic                   div_done;
  logic [DUTY_W-1:0]      div_quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      prev <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (rise)           cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cap_high   = 1'b0;
    cap_period = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: if (rise) state_nx = HIGH;
      HIGH: begin
        if (fall) begin
          cap_high = 1'b1;
          state_nx = LOW;
        end else if (cnt == CNT_MAX) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          cap_period = 1'b1;
          state_nx   = HIGH;
        end else if (cnt == CNT_MAX) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A divider finishing this cycle frees it in time to take the new period.
  assign accept  = cap_period & (~div_busy | div_done);
  assign overrun = cap_period & ~accept;

  pwm_meas_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .num   (high_r),
    .den   (cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // Pending copies keep the reported period/high tied to the divide in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_r      <= '0;
      pend_period <= '0;
      pend_high   <= '0;
      period_o    <= '0;
      high_o      <= '0;
      duty_o      <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      meas_valid <= div_done;
      if (cap_high) high_r <= cnt;
      if (accept) begin
        pend_period <= cnt;
        pend_high   <= high_r;
      end
      if (div_done) begin
        period_o <= pend_period;
        high_o   <= pend_high;
        duty_o   <= div_quo;
      end
      if (timeout)       stuck <= 1'b1;
      else if (div_done) stuck <= 1'b0;
    end
  end

endmodule
